// File: rtl/ga23_pkg.sv
// Shared GA23 tilemap types: scheduler state/owner enums and rowscroll table bases.
// Pure declarations plus one address helper; no state.
// No flow control of its own.
package ga23_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  typedef enum logic [2:0] {
    OWN_RS  = 3'd0,
    OWN_L0  = 3'd1,
    OWN_L1  = 3'd2,
    OWN_L2  = 3'd3,
    OWN_CPU = 3'd4
  } owner_t;

  localparam logic [14:0] GA23_RS_BASE0 = 15'h7a00;
  localparam logic [14:0] GA23_RS_BASE1 = 15'h7c00;
  localparam logic [14:0] GA23_RS_BASE2 = 15'h7e00;

  // Rowscroll entry address: the 10-bit line sum wraps and only its low 9 bits index the table.
  function automatic logic [14:0] rs_addr(input logic [14:0] base, input logic [9:0] y,
                                          input logic [9:0] line);
    logic [9:0] sum;
    sum = y + line;
    return base + ({5'b0, sum} & 15'h01ff);
  endfunction

endpackage

// File: rtl/ga23_rr3.sv
// Three-way round-robin picker: first requester found searching upward from ptr (mod 3).
// Purely combinational, zero latency.
// No backpressure; valid simply mirrors any request.
module ga23_rr3 (
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [1:0] o_grant,
  output logic       o_valid
);

  // Priority search in rotated order p, p+1, p+2 (mod 3)
  always_comb begin
    o_valid = |i_req;
    o_grant = 2'd0;
    case (i_ptr)
      2'd1: begin
        if (i_req[1])      o_grant = 2'd1;
        else if (i_req[2]) o_grant = 2'd2;
        else               o_grant = 2'd0;
      end
      2'd2: begin
        if (i_req[2])      o_grant = 2'd2;
        else if (i_req[0]) o_grant = 2'd0;
        else               o_grant = 2'd1;
      end
      default: begin
        if (i_req[0])      o_grant = 2'd0;
        else if (i_req[1]) o_grant = 2'd1;
        else               o_grant = 2'd2;
      end
    endcase
  end

endmodule

// File: rtl/ga23_vram_sched.sv
// GA23 VRAM port scheduler: rowscroll fetch > layers (round-robin) > CPU, toggle req/ack to VRAM.
// Latency: strobe N+3 cycles after the IDLE grant when vram_ack toggles N cycles after vram_req.
// Backpressure: requesters hold level requests until their one-cycle strobe; CPU port only with GA23_CPU_PORT_EN.
module ga23_vram_sched
  import ga23_pkg::*;
#(
  parameter logic [14:0] RS_BASE0 = GA23_RS_BASE0,
  parameter logic [14:0] RS_BASE1 = GA23_RS_BASE1,
  parameter logic [14:0] RS_BASE2 = GA23_RS_BASE2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        hpulse,
  input  logic [9:0]  ve,
  input  logic [29:0] y_ofs,
  input  logic [2:0]  layer_req,
  input  logic [44:0] layer_addr,
  output logic [2:0]  layer_load,
  output logic [31:0] vram_data,
  output logic [29:0] rowscroll,
  input  logic        cpu_req,
  input  logic [14:0] cpu_addr,
  output logic        cpu_ack,
  output logic [14:0] vram_addr,
  output logic        vram_req,
  input  logic        vram_ack,
  input  logic [31:0] vram_din
);

  sched_state_t r_state, w_state_nxt;
  owner_t       r_owner, w_owner_nxt;
  logic         r_ack_seen, r_vram_req;
  logic [14:0]  r_vram_addr, w_issue_addr;
  logic [31:0]  r_vram_data;
  logic [29:0]  r_rowscroll;
  logic [2:0]   r_layer_load;
  logic [1:0]   r_rr, r_rs_idx;
  logic         r_rs_pending, r_rs_discard;
  logic [1:0]   w_rr_grant;
  logic         w_rr_vld, w_ack_new, w_restart;
  logic         w_grant_rs, w_grant_layer, w_grant_cpu, w_issue, w_capture;

  assign w_ack_new = (vram_ack != r_ack_seen);
  assign w_restart = hpulse & ce;

  ga23_rr3 u_rr3 (
    .i_req   (layer_req),
    .i_ptr   (r_rr),
    .o_grant (w_rr_grant),
    .o_valid (w_rr_vld)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_owner <= OWN_RS;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // Next-state and winner selection
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      IDLE: begin
        if (w_grant_rs) begin
          w_owner_nxt = OWN_RS;
          w_state_nxt = ISSUE;
        end else if (w_grant_layer) begin
          case (w_rr_grant)
            2'd0:    w_owner_nxt = OWN_L0;
            2'd1:    w_owner_nxt = OWN_L1;
            default: w_owner_nxt = OWN_L2;
          endcase
          w_state_nxt = ISSUE;
        end else if (w_grant_cpu) begin
          w_owner_nxt = OWN_CPU;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (w_ack_new) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Per-state action decode
  always_comb begin
    w_grant_rs    = 1'b0;
    w_grant_layer = 1'b0;
    w_grant_cpu   = 1'b0;
    w_issue       = 1'b0;
    w_capture     = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_rs    = r_rs_pending;
        w_grant_layer = !r_rs_pending && w_rr_vld;
`ifdef GA23_CPU_PORT_EN
        w_grant_cpu   = !r_rs_pending && !w_rr_vld && cpu_req;
`endif
      end
      ISSUE:   w_issue   = 1'b1;
      WAIT:    w_capture = w_ack_new;
      default: ;
    endcase
  end

  // Address of the current owner; line/offset inputs are sampled here, in ISSUE
  always_comb begin
    w_issue_addr = 15'd0;
    case (r_owner)
      OWN_RS: begin
        case (r_rs_idx)
          2'd0:    w_issue_addr = rs_addr(RS_BASE0, y_ofs[9:0], ve);
          2'd1:    w_issue_addr = rs_addr(RS_BASE1, y_ofs[19:10], ve);
          default: w_issue_addr = rs_addr(RS_BASE2, y_ofs[29:20], ve);
        endcase
      end
      OWN_L0:  w_issue_addr = layer_addr[14:0];
      OWN_L1:  w_issue_addr = layer_addr[29:15];
      OWN_L2:  w_issue_addr = layer_addr[44:30];
`ifdef GA23_CPU_PORT_EN
      OWN_CPU: w_issue_addr = cpu_addr;
`endif
      default: ;
    endcase
  end

  // VRAM handshake, data capture, layer strobes and round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vram_req   <= 1'b0;
      r_ack_seen   <= 1'b0;
      r_vram_addr  <= 15'd0;
      r_vram_data  <= 32'd0;
      r_layer_load <= 3'd0;
      r_rr         <= 2'd0;
    end else begin
      r_layer_load <= 3'd0;
      if (w_issue) begin
        r_vram_addr <= w_issue_addr;
        r_vram_req  <= ~r_vram_req;
      end
      if (w_capture) begin
        r_vram_data <= vram_din;
        r_ack_seen  <= vram_ack;
        r_layer_load[0] <= (r_owner == OWN_L0);
        r_layer_load[1] <= (r_owner == OWN_L1);
        r_layer_load[2] <= (r_owner == OWN_L2);
      end
      if (w_grant_layer) r_rr <= (w_rr_grant == 2'd2) ? 2'd0 : w_rr_grant + 2'd1;
    end
  end

  // Rowscroll sequencer: a line pulse restarts at entry 0 and voids any rowscroll read in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rs_pending <= 1'b0;
      r_rs_idx     <= 2'd0;
      r_rs_discard <= 1'b0;
      r_rowscroll  <= 30'd0;
    end else if (w_restart) begin
      r_rs_pending <= 1'b1;
      r_rs_idx     <= 2'd0;
      r_rs_discard <= (r_owner == OWN_RS) &&
                      ((r_state == ISSUE) || ((r_state == WAIT) && !w_ack_new));
    end else if (w_capture && (r_owner == OWN_RS)) begin
      if (r_rs_discard) begin
        r_rs_discard <= 1'b0;
      end else begin
        case (r_rs_idx)
          2'd0:    r_rowscroll[9:0]   <= vram_din[9:0];
          2'd1:    r_rowscroll[19:10] <= vram_din[9:0];
          default: r_rowscroll[29:20] <= vram_din[9:0];
        endcase
        if (r_rs_idx == 2'd2) begin
          r_rs_idx     <= 2'd0;
          r_rs_pending <= 1'b0;
        end else begin
          r_rs_idx <= r_rs_idx + 2'd1;
        end
      end
    end
  end

`ifdef GA23_CPU_PORT_EN
  logic r_cpu_ack;

  // CPU completion strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_cpu_ack <= 1'b0;
    else          r_cpu_ack <= w_capture && (r_owner == OWN_CPU);
  end

  assign cpu_ack = r_cpu_ack;
`else
  logic w_unused_cpu;
  assign w_unused_cpu = ^{cpu_req, cpu_addr};
  assign cpu_ack      = 1'b0;
`endif

  assign layer_load = r_layer_load;
  assign vram_data  = r_vram_data;
  assign rowscroll  = r_rowscroll;
  assign vram_addr  = r_vram_addr;
  assign vram_req   = r_vram_req;

endmodule
